// File: rtl/led_strip_renderer.sv
// rtl/led_strip_renderer.sv - WS2812-style serialiser rendering race/menu game state, one LED per track position
`timescale 1ns/1ps
module led_strip_renderer #(
  parameter int          MAX_POS   = 16,
  parameter int          T0H_CLK   = 20,
  parameter int          T1H_CLK   = 40,
  parameter int          BIT_CLK   = 62,
  parameter int          RESET_CLK = 2500,
  parameter logic [7:0]  BRIGHT    = 8'h10,
  localparam int         PW        = (MAX_POS > 1) ? $clog2(MAX_POS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [PW-1:0] red_cur_pos,
  input  logic [PW-1:0] blue_cur_pos,
  input  logic [PW-1:0] green_cur_pos,
  input  logic [PW-1:0] yellow_cur_pos,
  input  logic          red_ready_to_play,
  input  logic          blue_ready_to_play,
  input  logic          green_ready_to_play,
  input  logic          yellow_ready_to_play,
  input  logic          is_in_menu,
  input  logic [2:0]    countdown,
  output logic          leds_line,
  output logic          busy,
  output logic          frame_done
);

  localparam int CNT_MAX = (RESET_CLK > BIT_CLK) ? RESET_CLK : BIT_CLK;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [23:0] C_RED    = {8'h00, BRIGHT, 8'h00};
  localparam logic [23:0] C_BLUE   = {16'h0000, BRIGHT};
  localparam logic [23:0] C_GREEN  = {BRIGHT, 16'h0000};
  localparam logic [23:0] C_YELLOW = {BRIGHT, BRIGHT, 8'h00};
  localparam logic [23:0] C_WHITE  = {BRIGHT, BRIGHT, BRIGHT};

  typedef enum logic [1:0] {
    ST_GAP  = 2'b00,
    ST_LOAD = 2'b01,
    ST_HIGH = 2'b11,
    ST_LOW  = 2'b10
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   led_idx_q, led_idx_d;
  logic [4:0]      bit_idx_q, bit_idx_d;
  logic [23:0]     shift_q, shift_d;
  logic            frame_done_q, frame_done_d;

  // Frame snapshot: everything after LED0 is coloured from these, never from live inputs.
  logic [PW-1:0]   snap_red_q, snap_red_d;
  logic [PW-1:0]   snap_blue_q, snap_blue_d;
  logic [PW-1:0]   snap_green_q, snap_green_d;
  logic [PW-1:0]   snap_yellow_q, snap_yellow_d;
  logic [3:0]      snap_ready_q, snap_ready_d;
  logic            snap_menu_q, snap_menu_d;
  logic [2:0]      snap_cd_q, snap_cd_d;

  function automatic logic [23:0] colour_of(
    input logic [PW-1:0] idx,
    input logic          menu,
    input logic [2:0]    cd,
    input logic [PW-1:0] rp,
    input logic [PW-1:0] bp,
    input logic [PW-1:0] gp,
    input logic [PW-1:0] yp,
    input logic [3:0]    rdy
  );
    logic [23:0] c;
    int          lim;
    c   = 24'h0;
    lim = (int'(cd) > MAX_POS) ? MAX_POS : int'(cd);
    if (menu) begin
      // The countdown lights the tail of the strip white and beats the ready markers.
      if (int'(idx) >= MAX_POS - lim)          c = C_WHITE;
      else if (int'(idx) == 0 && rdy[0])       c = C_RED;
      else if (int'(idx) == 1 && rdy[1])       c = C_BLUE;
      else if (int'(idx) == 2 && rdy[2])       c = C_GREEN;
      else if (int'(idx) == 3 && rdy[3])       c = C_YELLOW;
    end else begin
      if (rp == idx)      c = C_RED;
      else if (bp == idx) c = C_BLUE;
      else if (gp == idx) c = C_GREEN;
      else if (yp == idx) c = C_YELLOW;
    end
    return c;
  endfunction

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    led_idx_d     = led_idx_q;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    frame_done_d  = 1'b0;
    snap_red_d    = snap_red_q;
    snap_blue_d   = snap_blue_q;
    snap_green_d  = snap_green_q;
    snap_yellow_d = snap_yellow_q;
    snap_ready_d  = snap_ready_q;
    snap_menu_d   = snap_menu_q;
    snap_cd_d     = snap_cd_q;

    case (state_q)
      ST_GAP: begin
        if (cnt_q == CW'(RESET_CLK - 1)) begin
          cnt_d   = '0;
          state_d = ST_LOAD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_LOAD: begin
        snap_red_d    = red_cur_pos;
        snap_blue_d   = blue_cur_pos;
        snap_green_d  = green_cur_pos;
        snap_yellow_d = yellow_cur_pos;
        snap_ready_d  = {yellow_ready_to_play, green_ready_to_play,
                         blue_ready_to_play, red_ready_to_play};
        snap_menu_d   = is_in_menu;
        snap_cd_d     = countdown;
        led_idx_d     = '0;
        bit_idx_d     = 5'd23;
        cnt_d         = '0;
        // The snapshot is only being written this cycle, so LED0 colours from the live inputs.
        shift_d       = colour_of('0, is_in_menu, countdown, red_cur_pos, blue_cur_pos,
                                  green_cur_pos, yellow_cur_pos,
                                  {yellow_ready_to_play, green_ready_to_play,
                                   blue_ready_to_play, red_ready_to_play});
        state_d       = ST_HIGH;
      end
      ST_HIGH: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == (shift_q[23] ? CW'(T1H_CLK - 1) : CW'(T0H_CLK - 1))) state_d = ST_LOW;
      end
      ST_LOW: begin
        if (cnt_q == CW'(BIT_CLK - 1)) begin
          cnt_d = '0;
          if (bit_idx_q != 5'd0) begin
            shift_d   = {shift_q[22:0], 1'b0};
            bit_idx_d = bit_idx_q - 1'b1;
            state_d   = ST_HIGH;
          end else if (led_idx_q != PW'(MAX_POS - 1)) begin
            led_idx_d = led_idx_q + 1'b1;
            bit_idx_d = 5'd23;
            shift_d   = colour_of(led_idx_q + 1'b1, snap_menu_q, snap_cd_q, snap_red_q,
                                  snap_blue_q, snap_green_q, snap_yellow_q, snap_ready_q);
            state_d   = ST_HIGH;
          end else begin
            frame_done_d = 1'b1;
            state_d      = ST_GAP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_GAP;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_GAP;
      cnt_q         <= '0;
      led_idx_q     <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      frame_done_q  <= 1'b0;
      snap_red_q    <= '0;
      snap_blue_q   <= '0;
      snap_green_q  <= '0;
      snap_yellow_q <= '0;
      snap_ready_q  <= '0;
      snap_menu_q   <= 1'b0;
      snap_cd_q     <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      led_idx_q     <= led_idx_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      frame_done_q  <= frame_done_d;
      snap_red_q    <= snap_red_d;
      snap_blue_q   <= snap_blue_d;
      snap_green_q  <= snap_green_d;
      snap_yellow_q <= snap_yellow_d;
      snap_ready_q  <= snap_ready_d;
      snap_menu_q   <= snap_menu_d;
      snap_cd_q     <= snap_cd_d;
    end
  end

  // Decoded straight from the state register so an async reset drops the line at once.
  assign leds_line  = (state_q == ST_HIGH);
  assign busy       = (state_q == ST_HIGH) || (state_q == ST_LOW);
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_led_strip_renderer.sv
// tb/tb_led_strip_renderer.sv - scoreboard bench decoding the strip line back into GRB words
`timescale 1ns/1ps
module tb_led_strip_renderer;

  localparam int MAX_POS = 8;
  localparam int T0H     = 2;
  localparam int T1H     = 4;
  localparam int BITC    = 6;
  localparam int RSTC    = 10;
  localparam int PERIOD  = RSTC + 1 + MAX_POS * 24 * BITC;

  localparam logic [23:0] C_R = 24'h001000;
  localparam logic [23:0] C_B = 24'h000010;
  localparam logic [23:0] C_G = 24'h100000;
  localparam logic [23:0] C_W = 24'h101010;
  localparam logic [23:0] C_O = 24'h000000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] red_pos, blue_pos, green_pos, yellow_pos;
  logic       red_rdy, blue_rdy, green_rdy, yellow_rdy;
  logic       in_menu;
  logic [2:0] countdown;
  logic       leds_line, busy, frame_done;

  int tests = 0;
  int fails = 0;
  logic [23:0] exp_q[$];

  led_strip_renderer #(
    .MAX_POS(MAX_POS), .T0H_CLK(T0H), .T1H_CLK(T1H), .BIT_CLK(BITC),
    .RESET_CLK(RSTC), .BRIGHT(8'h10)
  ) dut (
    .clk(clk), .reset(rst_n),
    .red_cur_pos(red_pos), .blue_cur_pos(blue_pos),
    .green_cur_pos(green_pos), .yellow_cur_pos(yellow_pos),
    .red_ready_to_play(red_rdy), .blue_ready_to_play(blue_rdy),
    .green_ready_to_play(green_rdy), .yellow_ready_to_play(yellow_rdy),
    .is_in_menu(in_menu), .countdown(countdown),
    .leds_line(leds_line), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [191:0] f);
    for (int i = 0; i < MAX_POS; i++) exp_q.push_back(f[191 - 24*i -: 24]);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 3 * PERIOD);
    check("frame_done_seen", frame_done, 1'b1);
  endtask

  // Call right after releasing reset at a negedge: gap, LOAD, then first bit high.
  task automatic check_startup(input string tag);
    logic hi_seen, busy_seen;
    int   n;
    hi_seen   = 1'b0;
    busy_seen = 1'b0;
    for (int i = 1; i <= RSTC; i++) begin
      @(negedge clk);
      hi_seen   = hi_seen | leds_line;
      busy_seen = busy_seen | busy;
    end
    check({tag, "_gap_line_low"}, hi_seen, 1'b0);
    check({tag, "_gap_busy_low"}, busy_seen, 1'b0);
    @(negedge clk);
    check({tag, "_first_bit_high"}, leds_line, 1'b1);
    check({tag, "_busy_after_load"}, busy, 1'b1);
    wait_done(n);
    check({tag, "_latency"}, n + RSTC + 1, PERIOD);
    check({tag, "_frame_consumed"}, exp_q.size(), 0);
  endtask

  // Line decoder: rebuilds each 24-bit word and checks it against the scoreboard head.
  int          hi_cnt, low_run, since_rise, nbits, led_no;
  logic        prev;
  logic [23:0] word;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev = 1'b0; hi_cnt = 0; low_run = 1000; since_rise = 0;
      nbits = 0; led_no = 0; word = '0;
    end else begin
      since_rise++;
      if (leds_line) begin
        if (!prev) begin
          if (low_run > BITC) begin
            nbits  = 0;
            led_no = 0;
          end else begin
            check("bit_period", since_rise, BITC);
          end
          since_rise = 0;
          hi_cnt     = 0;
        end
        hi_cnt++;
        low_run = 0;
      end else begin
        if (prev) begin
          check("high_width_legal", (hi_cnt == T0H) || (hi_cnt == T1H), 1'b1);
          word = {word[22:0], (hi_cnt > T0H)};
          nbits++;
          if (nbits == 24) begin
            if (exp_q.size() > 0) check($sformatf("led%0d_grb", led_no), word, exp_q.pop_front());
            nbits = 0;
            led_no++;
          end
        end
        low_run++;
      end
      prev = leds_line;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    red_pos = 3'd3; blue_pos = 3'd7; green_pos = 3'd7; yellow_pos = 3'd7;
    red_rdy = 1'b0; blue_rdy = 1'b0; green_rdy = 1'b0; yellow_rdy = 1'b0;
    in_menu = 1'b0; countdown = 3'd0;
    repeat (3) @(negedge clk);
    check("rst_line", leds_line, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);

    // Race frame, blue wins the shared position 7.
    push_frame({C_O, C_O, C_O, C_R, C_O, C_O, C_O, C_B});
    rst_n = 1'b1;
    check_startup("boot");
    @(negedge clk);
    check("frame_done_one_cycle", frame_done, 1'b0);
    push_frame({C_O, C_O, C_O, C_R, C_O, C_O, C_O, C_B});
    wait_done(n);
    check("frame_period", n + 1, PERIOD);
    check("frame2_consumed", exp_q.size(), 0);

    // Mid-frame position change must not tear the current frame.
    push_frame({C_O, C_O, C_O, C_R, C_O, C_O, C_O, C_B});
    repeat (300) @(negedge clk);
    red_pos = 3'd5;
    wait_done(n);
    check("no_tear_consumed", exp_q.size(), 0);
    push_frame({C_O, C_O, C_O, C_O, C_O, C_R, C_O, C_B});
    wait_done(n);
    check("moved_consumed", exp_q.size(), 0);

    // Menu: ready markers plus countdown tail.
    in_menu = 1'b1; red_rdy = 1'b1; green_rdy = 1'b1; countdown = 3'd2;
    push_frame({C_R, C_O, C_G, C_O, C_O, C_O, C_W, C_W});
    wait_done(n);
    check("menu_cd2_consumed", exp_q.size(), 0);
    countdown = 3'd7;
    push_frame({C_R, C_W, C_W, C_W, C_W, C_W, C_W, C_W});
    wait_done(n);
    check("menu_cd7_consumed", exp_q.size(), 0);

    // Everyone on position 0: red has priority.
    in_menu = 1'b0;
    red_pos = 3'd0; blue_pos = 3'd0; green_pos = 3'd0; yellow_pos = 3'd0;
    push_frame({C_R, C_O, C_O, C_O, C_O, C_O, C_O, C_O});
    wait_done(n);
    check("shared_pos_consumed", exp_q.size(), 0);

    // Reset in the second cycle of bit 10 of LED4 (offset 11 + (4*24+13)*6 + 1 edges).
    push_frame({C_R, C_O, C_O, C_O, C_O, C_O, C_O, C_O});
    repeat (666) @(posedge clk);
    #1;
    check("mid_bit_line_high", leds_line, 1'b1);
    check("mid_frame_leds_done", exp_q.size(), 4);
    rst_n = 1'b0;
    #1;
    check("async_rst_line", leds_line, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    push_frame({C_R, C_O, C_O, C_O, C_O, C_O, C_O, C_O});
    rst_n = 1'b1;
    check_startup("rerun");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
